// File: rtl/sniffer_match_logger_if.sv
// rtl/sniffer_match_logger_if.sv - FIFO readout port of the sniffer match logger
interface sniffer_match_logger_if #(
    parameter int WIDTH    = 32,
    parameter int TS_WIDTH = 32,
    parameter int DEPTH    = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                rd_en;
    logic [WIDTH-1:0]    rd_addr;
    logic [TS_WIDTH-1:0] rd_ts;
    logic                rd_valid;
    logic                empty;
    logic                full;
    logic [LW-1:0]       level;

    modport master (output rd_en, input rd_addr, rd_ts, rd_valid, empty, full, level);
    modport slave  (input rd_en, output rd_addr, rd_ts, rd_valid, empty, full, level);
endinterface

// File: rtl/sniffer_match_logger.sv
// rtl/sniffer_match_logger.sv - logs comparator hits {addr, timestamp} into a FIFO with threshold irq/auto-stop
// Optional timestamp capture enabled by defining MATCH_LOG_TIMESTAMP_EN.
module sniffer_match_logger #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int TS_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     addr,
    input  logic                 match,
    input  logic                 arm,
    input  logic                 stop,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] threshold,
    sniffer_match_logger_if.slave rd,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic                 overflow,
    output logic                 irq,
    output logic                 armed
);
    localparam int AW = $clog2(DEPTH);
`ifdef MATCH_LOG_TIMESTAMP_EN
    localparam int EW = WIDTH + TS_WIDTH;
`else
    localparam int EW = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, STOPPED} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     addr_d;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [EW-1:0]        mem [DEPTH];
    logic [EW-1:0]        wr_data, rd_word;
    logic [CNT_WIDTH-1:0] hit_cnt, hit_inc;
    logic                 ovf_q, irq_q;
    logic [WIDTH-1:0]     rd_addr_q;
    logic                 rd_valid_q;
    logic                 fifo_empty, fifo_full;
    logic                 hit, do_rd, do_wr, drop, thr_hit;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // clear discards any match or read presented in the same cycle
    assign hit     = (state == ARMED) && match && !clear;
    assign do_rd   = rd.rd_en && !fifo_empty && !clear;
    assign do_wr   = hit && (!fifo_full || do_rd);
    assign drop    = hit && fifo_full && !do_rd;
    assign hit_inc = (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;
    // only an exact transition onto the threshold fires, never a live lowering below the count
    assign thr_hit = hit && (threshold != '0) && (hit_cnt != threshold) && (hit_inc == threshold);

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (arm && !stop)      state_nx = ARMED;
                ARMED:   if (stop || thr_hit)   state_nx = STOPPED;
                STOPPED: if (arm && !stop)      state_nx = ARMED;
                default:                        state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr_d  <= '0;
            hit_cnt <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_d <= addr;
            irq_q  <= thr_hit;
            if (clear) begin
                hit_cnt <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (state != ARMED && state_nx == ARMED) begin
                    hit_cnt <= '0;
                end else if (hit) begin
                    hit_cnt <= hit_inc;
                end
                if (drop) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            rd_valid_q <= do_rd;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_addr_q <= rd_word[EW-1 -: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_word = mem[rd_ptr[AW-1:0]];

`ifdef MATCH_LOG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts, rd_ts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts      <= '0;
            rd_ts_q <= '0;
        end else begin
            ts <= clear ? '0 : ts + 1'b1;
            if (do_rd) begin
                rd_ts_q <= rd_word[TS_WIDTH-1:0];
            end
        end
    end

    assign wr_data  = {addr_d, ts};
    assign rd.rd_ts = rd_ts_q;
`else
    assign wr_data  = addr_d;
    assign rd.rd_ts = {TS_WIDTH{1'b0}};
`endif

    assign rd.rd_addr  = rd_addr_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.empty    = fifo_empty;
    assign rd.full     = fifo_full;
    assign rd.level    = wr_ptr - rd_ptr;
    assign hit_count   = hit_cnt;
    assign overflow    = ovf_q;
    assign irq         = irq_q;
    assign armed       = (state == ARMED);
endmodule
